sort_engine: RTL and testbench



---
 rtl/sort_engine.sv | 134 +++++++++++++
 tb/tb_sort_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sort_engine.sv
// In-place bubble sort over a small register array, with host write/read access.
// Passes end early once a full pass makes no swap.
//
// state   | meaning
// IDLE    | host may write/read memory; waits for s
// RD_PAIR | register a = mem[j], b = mem[j+1]
// CMP     | decide whether the pair is out of order
// SWAP    | write the pair back exchanged, flag the pass
// NEXT    | advance j, or start another pass, or finish
// DONE    | sort complete; reads allowed, waits for s low
module sort_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  desc,
    input  logic                  wrin,
    input  logic                  rd,
    input  logic [ADDR_WIDTH-1:0] Radd,
    input  logic [DATA_WIDTH-1:0] datain,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  busy,
    output logic                  done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_N = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   ONE_N   = 1;
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = 1;

    typedef enum logic [2:0] {
        IDLE, RD_PAIR, CMP, SWAP, NEXT, DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] a, b;
    logic [ADDR_WIDTH-1:0] j;
    logic [ADDR_WIDTH:0]   n;
    logic [ADDR_WIDTH:0]   n_start;
    logic                  swapped;
    logic                  desc_q;
    logic                  gt, lt, out_of_order, more;

    assign n_start = (len > DEPTH_N) ? DEPTH_N : len;

    always_comb begin
        if (SIGNED != 0) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
    end

    // Equal values fall through to NEXT, keeping the sort stable.
    assign out_of_order = desc_q ? lt : gt;
    assign more         = ({1'b0, j} + ONE_N) < (n - ONE_N);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s) state_nxt = (n_start <= ONE_N) ? DONE : RD_PAIR;
            RD_PAIR: state_nxt = CMP;
            CMP:     state_nxt = out_of_order ? SWAP : NEXT;
            SWAP:    state_nxt = NEXT;
            NEXT:    state_nxt = (more || swapped) ? RD_PAIR : DONE;
            DONE:    if (!s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j       <= '0;
            n       <= '0;
            swapped <= 1'b0;
            desc_q  <= 1'b0;
            a       <= '0;
            b       <= '0;
            DOUT    <= '0;
        end else begin
            if (rd && (state == IDLE || state == DONE))
                DOUT <= mem[Radd];
            case (state)
                IDLE: if (s) begin
                    desc_q  <= desc;
                    n       <= n_start;
                    j       <= '0;
                    swapped <= 1'b0;
                end
                RD_PAIR: begin
                    a <= mem[j];
                    b <= mem[j + ONE_A];
                end
                SWAP: swapped <= 1'b1;
                NEXT: begin
                    if (more) begin
                        j <= j + ONE_A;
                    end else if (swapped) begin
                        swapped <= 1'b0;
                        j       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Both halves of a swap land on one edge, so a reset can never split a swap.
    always_ff @(posedge clk) begin
        if (state == IDLE && wrin) begin
            mem[Radd] <= datain;
        end else if (state == SWAP) begin
            mem[j]         <= b;
            mem[j + ONE_A] <= a;
        end
    end

endmodule

// File: tb/tb_sort_engine.sv
// Directed bench for sort_engine: an unsigned and a signed instance share all host inputs,
// so every sort runs on both and each is checked against hand-computed results.
module tb_sort_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s = 1'b0;
    logic [3:0] len = '0;
    logic       desc = 1'b0;
    logic       wrin = 1'b0;
    logic       rd = 1'b0;
    logic [2:0] Radd = '0;
    logic [7:0] datain = '0;
    logic [7:0] dout_u, dout_s;
    logic       busy_u, busy_s, done_u, done_s;

    int n_checks = 0;
    int n_fail   = 0;

    sort_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .s(s), .len(len), .desc(desc), .wrin(wrin), .rd(rd),
        .Radd(Radd), .datain(datain), .DOUT(dout_u), .busy(busy_u), .done(done_u)
    );

    sort_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .s(s), .len(len), .desc(desc), .wrin(wrin), .rd(rd),
        .Radd(Radd), .datain(datain), .DOUT(dout_s), .busy(busy_s), .done(done_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        wrin = 1'b1; Radd = addr; datain = data;
        @(negedge clk);
        wrin = 1'b0;
    endtask

    task automatic load4(input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3);
        wr(3'd0, d0); wr(3'd1, d1); wr(3'd2, d2); wr(3'd3, d3);
    endtask

    task automatic rdm(input logic [2:0] addr, output logic [7:0] du, output logic [7:0] ds);
        @(negedge clk);
        rd = 1'b1; Radd = addr;
        @(posedge clk); #1;
        du = dout_u; ds = dout_s;
        @(negedge clk);
        rd = 1'b0;
    endtask

    // Start a sort, count edges (start edge = 1) until the unsigned instance reports done.
    task automatic run_sort(input logic [3:0] l, input logic d, input bit poke,
                            output int cyc, output bit saw_busy);
        bit both_done;
        @(negedge clk);
        len = l; desc = d; s = 1'b1;
        cyc = 0; saw_busy = 1'b0; both_done = 1'b0;
        for (int i = 1; i <= 2000; i++) begin
            @(posedge clk); #1;
            wrin = 1'b0;
            if (busy_u) saw_busy = 1'b1;
            if (done_u && cyc == 0) cyc = i;
            if (done_u && done_s) begin
                both_done = 1'b1;
                break;
            end
            if (poke && i == 3) begin
                wrin = 1'b1; Radd = 3'd0; datain = 8'hEE; desc = ~d; len = 4'd2;
            end
        end
        wrin = 1'b0;
        chk("sort_timeout", {31'd0, both_done}, 32'd1);
        @(posedge clk); #1;
        chk("done_held", {31'd0, done_u}, 32'd1);
        chk("busy_low_in_done", {31'd0, busy_u}, 32'd0);
        @(negedge clk);
        s = 1'b0;
        @(posedge clk); #1;
        chk("done_fall", {31'd0, done_u}, 32'd0);
    endtask

    logic [7:0] du, ds;
    int         cyc;
    bit         sb;

    initial begin
        #2;
        chk("rst_busy", {31'd0, busy_u}, 32'd0);
        chk("rst_done", {31'd0, done_u}, 32'd0);
        chk("rst_dout", {24'd0, dout_u}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Ascending: A3,A1,A2,A0 -> A0..A3, with markers in 4-7
        load4(8'h40, 8'h20, 8'h30, 8'h10);
        wr(3'd4, 8'h55); wr(3'd5, 8'h66); wr(3'd6, 8'h77); wr(3'd7, 8'h88);
        run_sort(4'd4, 1'b0, 1'b0, cyc, sb);
        chk("asc_busy_seen", {31'd0, sb}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            rdm(3'(i), du, ds);
            chk($sformatf("asc_rd%0d", i), {24'd0, du}, 32'h10 * (i + 1));
        end
        @(posedge clk); #1;
        chk("dout_hold", {24'd0, dout_u}, 32'h40);

        // Descending on the same data
        load4(8'h40, 8'h20, 8'h30, 8'h10);
        run_sort(4'd4, 1'b1, 1'b0, cyc, sb);
        for (int i = 0; i < 4; i++) begin
            rdm(3'(i), du, ds);
            chk($sformatf("desc_rd%0d", i), {24'd0, du}, 32'h10 * (4 - i));
        end
        for (int i = 4; i < 8; i++) begin
            rdm(3'(i), du, ds);
            chk($sformatf("desc_untouched%0d", i), {24'd0, du}, 32'h55 + 32'h11 * (i - 4));
        end

        // Signed vs unsigned compare
        load4(8'h7F, 8'h80, 8'h00, 8'hFF);
        run_sort(4'd4, 1'b0, 1'b0, cyc, sb);
        rdm(3'd0, du, ds); chk("uns_rd0", {24'd0, du}, 32'h00); chk("sgn_rd0", {24'd0, ds}, 32'h80);
        rdm(3'd1, du, ds); chk("uns_rd1", {24'd0, du}, 32'h7F); chk("sgn_rd1", {24'd0, ds}, 32'hFF);
        rdm(3'd2, du, ds); chk("uns_rd2", {24'd0, du}, 32'h80); chk("sgn_rd2", {24'd0, ds}, 32'h00);
        rdm(3'd3, du, ds); chk("uns_rd3", {24'd0, du}, 32'hFF); chk("sgn_rd3", {24'd0, ds}, 32'h7F);

        // Already sorted 01..08: early exit after one pass
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(i + 1));
        run_sort(4'd8, 1'b0, 1'b0, cyc, sb);
        chk("sorted_cycles", cyc, 32'd22);
        for (int i = 0; i < 8; i++) begin
            rdm(3'(i), du, ds);
            chk($sformatf("sorted_rd%0d", i), {24'd0, du}, 32'(i + 1));
        end

        // len=1: immediate done, busy never seen
        wr(3'd0, 8'h99);
        run_sort(4'd1, 1'b0, 1'b0, cyc, sb);
        chk("len1_cycles", cyc, 32'd1);
        chk("len1_no_busy", {31'd0, sb}, 32'd0);
        rdm(3'd0, du, ds);
        chk("len1_rd0", {24'd0, du}, 32'h99);

        // len=9 saturates to 8; write/desc/len changes during busy ignored
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(8 - i));
        run_sort(4'd9, 1'b0, 1'b1, cyc, sb);
        chk("len9_bound", {31'd0, (cyc >= 2 && cyc <= 225)}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            rdm(3'(i), du, ds);
            chk($sformatf("len9_rd%0d", i), {24'd0, du}, 32'(i + 1));
        end

        // Reset 5 cycles into a sort
        load4(8'h03, 8'h01, 8'h02, 8'h00);
        @(negedge clk);
        len = 4'd4; desc = 1'b0; s = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_busy", {31'd0, busy_u}, 32'd1);
        chk("pre_rst_dout_nz", {31'd0, (dout_u != 8'h00)}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy_u}, 32'd0);
        chk("mid_rst_done", {31'd0, done_u}, 32'd0);
        chk("mid_rst_dout", {24'd0, dout_u}, 32'd0);
        s = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        load4(8'h03, 8'h01, 8'h02, 8'h00);
        run_sort(4'd4, 1'b0, 1'b0, cyc, sb);
        for (int i = 0; i < 4; i++) begin
            rdm(3'(i), du, ds);
            chk($sformatf("post_rst_rd%0d", i), {24'd0, du}, 32'(i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
